// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl_pkg
// Description : Shared pipeline-control definitions for the 5-stage RV32
//               pipeline. Holds the mul/div sequencing state encoding and
//               the RV32 opcode constants used by the hazard unit.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_ctrl_pkg;

    // Mul/div sequencing state. Explicit 2-bit encoding; code 2'd3 is
    // unreachable and recovers to IDLE.
    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } md_state_t;

    // RV32 base opcodes (instr[6:0]).
    localparam logic [6:0] c_opc_load   = 7'b0000011;
    localparam logic [6:0] c_opc_store  = 7'b0100011;
    localparam logic [6:0] c_opc_op_imm = 7'b0010011;
    localparam logic [6:0] c_opc_op     = 7'b0110011;
    localparam logic [6:0] c_opc_branch = 7'b1100011;
    localparam logic [6:0] c_opc_jal    = 7'b1101111;
    localparam logic [6:0] c_opc_jalr   = 7'b1100111;
    localparam logic [6:0] c_opc_lui    = 7'b0110111;
    localparam logic [6:0] c_opc_auipc  = 7'b0010111;

    // funct7 value selecting the M extension within OP.
    localparam logic [6:0] c_funct7_muldiv = 7'b0000001;

    // True for any M-extension instruction (MUL*/DIV*/REM*).
    function automatic logic is_muldiv(input logic [6:0] opcode,
                                       input logic [6:0] funct7);
        return (opcode == c_opc_op) && (funct7 == c_funct7_muldiv);
    endfunction

endpackage
`default_nettype wire

// File: rtl/md_watchdog.sv
`default_nettype none
// ============================================================================
// Module      : md_watchdog
// Description : Timeout counter for the iterative mul/div unit. Cleared when
//               an operation starts, advances on every BUSY cycle, and flags
//               expiry on the cycle that lies MD_TIMEOUT-1 cycles after the
//               start pulse, unless the unit reports done in that cycle.
// Ports       : clk, rst   - clock, synchronous active-high reset
//               start      - mul/div start pulse (BUSY entry next cycle)
//               busy       - sequencer is in BUSY
//               done       - mul/div result valid this cycle
//               expire     - timeout reached this cycle (combinational)
// Revision    : 1.0 - initial release
// ============================================================================
module md_watchdog #(
    parameter int MD_TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic busy,
    input  logic done,
    output logic expire
);

    localparam int c_cnt_w = (MD_TIMEOUT > 2) ? $clog2(MD_TIMEOUT) : 1;
    // r_cnt holds the number of BUSY cycles already completed, so the
    // current BUSY cycle lies r_cnt+1 cycles after md_start. Expiry is due
    // on the cycle MD_TIMEOUT-1 after md_start.
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(MD_TIMEOUT - 2);

    logic [c_cnt_w-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (start) begin
            r_cnt <= '0;
        end else if (busy) begin
            r_cnt <= r_cnt + c_cnt_w'(1);
        end
    end

    assign expire = busy & ~done & (r_cnt == c_last);

endmodule
`default_nettype wire

// File: rtl/pipe_stall_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stall_sequencer
// Description : Central stall/flush sequencer for the 5-stage RV32 pipeline.
//               Merges front-end hazards (load-use, redirect) with back-end
//               stalls (iterative mul/div in EX, data-memory wait in MEM) and
//               drives all pipeline-register enables/flushes and the PC
//               enable. Owns the mul/div start/done handshake and watchdog.
// Ports       : clk, rst               - clock, synchronous active-high reset
//               load_stall, redirect   - front-end hazard inputs
//               ex_md_valid, md_done   - mul/div presence in EX / completion
//               dmem_req, dmem_ready   - MEM-stage access and completion
//               perf_clr               - clear stall_cnt
//               md_start, md_abort     - mul/div control pulses
//               *_en, *_flush          - pipeline-register enables/bubbles
//               md_timeout_err         - sticky watchdog error
//               stall_cnt              - cycles with pc_en low (wrapping)
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stall_sequencer
    import pipe_ctrl_pkg::*;
#(
    parameter int MD_TIMEOUT = 64,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_stall,
    input  logic             redirect,
    input  logic             ex_md_valid,
    input  logic             md_done,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    input  logic             perf_clr,
    output logic             md_start,
    output logic             md_abort,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_flush,
    output logic             mem_wb_flush,
    output logic             md_timeout_err,
    output logic [CNT_W-1:0] stall_cnt
);

    md_state_t        r_md_state;
    md_state_t        w_md_state_nxt;
    logic             w_mem_hold;
    logic             w_md_in_busy;
    logic             w_md_start_cond;
    logic             w_md_expire;
    logic             w_md_finish;
    logic             w_md_stall;
    logic             r_md_timeout_err;
    logic [CNT_W-1:0] r_stall_cnt;

    assign w_mem_hold      = dmem_req & ~dmem_ready;
    assign w_md_in_busy    = (r_md_state == MD_BUSY);
    assign w_md_start_cond = (r_md_state == MD_IDLE) & ex_md_valid;
    // A watchdog expiry ends BUSY exactly like a real md_done.
    assign w_md_finish     = w_md_in_busy & (md_done | w_md_expire);
    assign w_md_stall      = w_md_start_cond
                           | (w_md_in_busy & ~md_done & ~w_md_expire);

    md_watchdog #(
        .MD_TIMEOUT (MD_TIMEOUT)
    ) u_md_watchdog (
        .clk    (clk),
        .rst    (rst),
        .start  (w_md_start_cond),
        .busy   (w_md_in_busy),
        .done   (md_done),
        .expire (w_md_expire)
    );

    // ------------------------------------------------------------------
    // Mul/div FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_md_state <= MD_IDLE;
        end else begin
            r_md_state <= w_md_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Mul/div FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        w_md_state_nxt = r_md_state;
        case (r_md_state)
            MD_IDLE: begin
                if (ex_md_valid) begin
                    w_md_state_nxt = MD_BUSY;
                end
            end
            MD_BUSY: begin
                // A completion while MEM is held would otherwise be lost
                // because EX cannot advance; park it in DONE.
                if (w_md_finish) begin
                    w_md_state_nxt = w_mem_hold ? MD_DONE : MD_IDLE;
                end
            end
            MD_DONE: begin
                if (!w_mem_hold) begin
                    w_md_state_nxt = MD_IDLE;
                end
            end
            default: begin
                w_md_state_nxt = MD_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs: pulses and prioritised enable/flush pattern
    // ------------------------------------------------------------------
    always_comb begin
        md_start     = 1'b0;
        md_abort     = 1'b0;
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        id_ex_en     = 1'b1;
        ex_mem_en    = 1'b1;
        mem_wb_en    = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        mem_wb_flush = 1'b0;
        if (rst) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_mem_en    = 1'b0;
            mem_wb_en    = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
            mem_wb_flush = 1'b1;
        end else begin
            md_start = w_md_start_cond;
            md_abort = w_md_expire;
            // Exclusive priority: a lower condition is ignored entirely
            // while a higher one holds; the frozen instruction reasserts
            // its request on a later cycle.
            if (w_mem_hold) begin
                pc_en        = 1'b0;
                if_id_en     = 1'b0;
                id_ex_en     = 1'b0;
                ex_mem_en    = 1'b0;
                mem_wb_flush = 1'b1;
            end else if (w_md_stall) begin
                pc_en        = 1'b0;
                if_id_en     = 1'b0;
                id_ex_en     = 1'b0;
                ex_mem_flush = 1'b1;
            end else if (redirect) begin
                pc_en        = 1'b1;
                if_id_flush  = 1'b1;
                id_ex_flush  = 1'b1;
            end else if (load_stall) begin
                pc_en        = 1'b0;
                if_id_en     = 1'b0;
                id_ex_flush  = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Sticky watchdog error and stall performance counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_md_timeout_err <= 1'b0;
        end else if (w_md_expire) begin
            r_md_timeout_err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (perf_clr) begin
            r_stall_cnt <= '0;
        end else if (!pc_en) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign md_timeout_err = r_md_timeout_err;
    assign stall_cnt      = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stall_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_stall_sequencer
// Description : Self-checking bench for pipe_stall_sequencer: a vector table
//               for the combinational priority rules, hand sequences for the
//               multi-cycle mul/div, memory-wait, timeout and counter cases,
//               and a randomized phase against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stall_sequencer;

    localparam int TO    = 8;
    localparam int CW    = 4;
    localparam int N_RND = 3000;

    // Control vector: {pc,if_id,id_ex,ex_mem,mem_wb en, if_id,id_ex,ex_mem,
    // mem_wb flush, md_start, md_abort}
    localparam logic [10:0] C_RUN = 11'b11111_0000_00;
    localparam logic [10:0] C_RST = 11'b00000_1111_00;
    localparam logic [10:0] C_MEM = 11'b00001_0001_00;

    logic          clk = 1'b0;
    logic          rst, load_stall, redirect, ex_md_valid, md_done;
    logic          dmem_req, dmem_ready, perf_clr;
    logic          md_start, md_abort, pc_en, if_id_en, id_ex_en, ex_mem_en;
    logic          mem_wb_en, if_id_flush, id_ex_flush, ex_mem_flush;
    logic          mem_wb_flush, md_timeout_err;
    logic [CW-1:0] stall_cnt;
    logic [10:0]   ctl;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    pipe_stall_sequencer #(
        .MD_TIMEOUT (TO),
        .CNT_W      (CW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .load_stall     (load_stall),
        .redirect       (redirect),
        .ex_md_valid    (ex_md_valid),
        .md_done        (md_done),
        .dmem_req       (dmem_req),
        .dmem_ready     (dmem_ready),
        .perf_clr       (perf_clr),
        .md_start       (md_start),
        .md_abort       (md_abort),
        .pc_en          (pc_en),
        .if_id_en       (if_id_en),
        .id_ex_en       (id_ex_en),
        .ex_mem_en      (ex_mem_en),
        .mem_wb_en      (mem_wb_en),
        .if_id_flush    (if_id_flush),
        .id_ex_flush    (id_ex_flush),
        .ex_mem_flush   (ex_mem_flush),
        .mem_wb_flush   (mem_wb_flush),
        .md_timeout_err (md_timeout_err),
        .stall_cnt      (stall_cnt)
    );

    assign ctl = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                  if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush,
                  md_start, md_abort};

    typedef struct {
        string       name;
        logic        redirect;
        logic        load_stall;
        logic        dmem_req;
        logic        dmem_ready;
        logic [10:0] exp;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                     name, got, exp, $time);
        end
    endtask

    task automatic set_in(input logic i_rst, input logic i_ld,
                          input logic i_rd, input logic i_val,
                          input logic i_done, input logic i_req,
                          input logic i_rdy, input logic i_clr);
        rst         = i_rst;
        load_stall  = i_ld;
        redirect    = i_rd;
        ex_md_valid = i_val;
        md_done     = i_done;
        dmem_req    = i_req;
        dmem_ready  = i_rdy;
        perf_clr    = i_clr;
    endtask

    // Inputs change 1 time unit after the rising edge; checks happen 2 units
    // later, well clear of either edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------
    // Behavioural reference: an operation is "running" from the cycle after
    // its start until done/timeout; its result is "parked" when it finished
    // while MEM was holding, until MEM releases.
    // ------------------------------------------------------------------
    bit m_running, m_parked, m_err;
    int m_age, m_cnt;

    initial begin
        logic [4:0] e_en;
        logic [3:0] e_fl;
        logic       e_start, e_exp, e_fin, e_stall, e_hold;
        logic [10:0] e_ctl;

        tbl[0] = '{"tbl_idle",      1'b0, 1'b0, 1'b0, 1'b0, C_RUN};
        tbl[1] = '{"tbl_load",      1'b0, 1'b1, 1'b0, 1'b0, 11'b00111_0100_00};
        tbl[2] = '{"tbl_redir",     1'b1, 1'b0, 1'b0, 1'b0, 11'b11111_1100_00};
        tbl[3] = '{"tbl_redir_ld",  1'b1, 1'b1, 1'b0, 1'b0, 11'b11111_1100_00};
        tbl[4] = '{"tbl_mem_ready", 1'b0, 1'b0, 1'b1, 1'b1, C_RUN};
        tbl[5] = '{"tbl_mem_hold",  1'b0, 1'b0, 1'b1, 1'b0, C_MEM};
        tbl[6] = '{"tbl_hold_all",  1'b1, 1'b1, 1'b1, 1'b0, C_MEM};
        tbl[7] = '{"tbl_rdy_noreq", 1'b0, 1'b1, 1'b0, 1'b1, 11'b00111_0100_00};

        // ---------------- reset ----------------
        set_in(1, 0, 0, 1, 1, 0, 0, 0);
        tick();
        for (int k = 0; k < 2; k++) begin
            #2;
            chk("rst_ctl", 32'(ctl), 32'(C_RST));
            tick();
        end
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        chk("post_rst_ctl", 32'(ctl), 32'(C_RUN));
        chk("post_rst_cnt", 32'(stall_cnt), 0);
        chk("post_rst_err", 32'(md_timeout_err), 0);
        tick();

        // ---------------- priority table ----------------
        for (int i = 0; i < 8; i++) begin
            set_in(0, tbl[i].load_stall, tbl[i].redirect, 0, 0,
                   tbl[i].dmem_req, tbl[i].dmem_ready, 0);
            #2;
            chk(tbl[i].name, 32'(ctl), 32'(tbl[i].exp));
            tick();
        end

        // ---------------- mul/div normal + back-to-back ----------------
        set_in(0, 0, 0, 0, 0, 0, 0, 1);
        tick();
        for (int k = 0; k < 6; k++) begin
            set_in(0, 0, 0, 1, (k == 5), 0, 0, 0);
            #2;
            chk("md_start", 32'(md_start), 32'(k == 0));
            chk("md_pc_en", 32'(pc_en), 32'(k == 5));
            chk("md_exmem_flush", 32'(ex_mem_flush), 32'(k != 5));
            chk("md_exmem_en", 32'(ex_mem_en), 1);
            tick();
        end
        set_in(0, 0, 0, 1, 0, 0, 0, 0);
        #2;
        chk("b2b_start", 32'(md_start), 1);
        chk("md_cnt", 32'(stall_cnt), 5);
        tick();
        set_in(0, 0, 0, 1, 1, 0, 0, 0);
        #2;
        chk("b2b_done_ctl", 32'(ctl), 32'(C_RUN));
        tick();
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        chk("b2b_cnt", 32'(stall_cnt), 6);
        tick();

        // ---------------- done during memory wait ----------------
        set_in(0, 0, 0, 1, 0, 1, 0, 0);
        #2;
        chk("mw_start_ctl", 32'(ctl), 32'(11'b00001_0001_10));
        tick();
        set_in(0, 0, 0, 1, 0, 1, 0, 0);
        #2;
        chk("mw_busy_ctl", 32'(ctl), 32'(C_MEM));
        tick();
        set_in(0, 0, 0, 1, 1, 1, 0, 0);
        #2;
        chk("mw_done_ctl", 32'(ctl), 32'(C_MEM));
        tick();
        set_in(0, 0, 0, 1, 0, 1, 0, 0);
        #2;
        chk("mw_parked_ctl", 32'(ctl), 32'(C_MEM));
        tick();
        set_in(0, 0, 0, 1, 0, 1, 1, 0);
        #2;
        chk("mw_release_ctl", 32'(ctl), 32'(C_RUN));
        tick();
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        chk("mw_idle_ctl", 32'(ctl), 32'(C_RUN));
        tick();

        // ---------------- watchdog timeout ----------------
        for (int k = 0; k < 8; k++) begin
            set_in(0, 0, 0, 1, 0, 0, 0, 0);
            #2;
            chk("to_abort", 32'(md_abort), 32'(k == 7));
            chk("to_pc_en", 32'(pc_en), 32'(k == 7));
            chk("to_err_pre", 32'(md_timeout_err), 0);
            tick();
        end
        for (int k = 0; k < 3; k++) begin
            set_in(0, 0, 0, 0, 0, 0, 0, 0);
            #2;
            chk("to_after_ctl", 32'(ctl), 32'(C_RUN));
            chk("to_err_sticky", 32'(md_timeout_err), 1);
            tick();
        end

        // ---------------- stall counter wrap and clear ----------------
        set_in(0, 0, 0, 0, 0, 0, 0, 1);
        tick();
        for (int k = 0; k < 16; k++) begin
            set_in(0, 1, 0, 0, 0, 0, 0, 0);
            #2;
            chk("cnt_ramp", 32'(stall_cnt), 32'(k));
            tick();
        end
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        chk("cnt_wrap", 32'(stall_cnt), 0);
        tick();
        for (int k = 0; k < 3; k++) begin
            set_in(0, 1, 0, 0, 0, 0, 0, 0);
            tick();
        end
        set_in(0, 1, 0, 0, 0, 0, 0, 1);
        #2;
        chk("cnt_before_clr", 32'(stall_cnt), 3);
        tick();
        set_in(0, 1, 0, 0, 0, 0, 0, 0);
        #2;
        chk("cnt_after_clr", 32'(stall_cnt), 0);
        tick();

        // ---------------- randomized against the model ----------------
        set_in(1, 0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        m_running = 0; m_parked = 0; m_err = 0; m_age = 0; m_cnt = 0;
        for (int n = 0; n < N_RND; n++) begin
            set_in(($urandom_range(0, 299) == 0),
                   ($urandom_range(0, 3) == 0),
                   ($urandom_range(0, 4) == 0),
                   ($urandom_range(0, 2) == 0),
                   ($urandom_range(0, 5) == 0),
                   ($urandom_range(0, 1) == 0),
                   ($urandom_range(0, 1) == 0),
                   ($urandom_range(0, 63) == 0));
            #2;
            e_hold  = dmem_req & ~dmem_ready;
            e_exp   = m_running && (m_age == TO - 1) && !md_done;
            e_start = !m_running && !m_parked && ex_md_valid;
            e_fin   = m_running && (md_done || e_exp);
            e_stall = e_start || (m_running && !e_fin);
            e_en    = 5'b11111;
            e_fl    = 4'b0000;
            if (e_hold) begin
                e_en = 5'b00001; e_fl = 4'b0001;
            end else if (e_stall) begin
                e_en = 5'b00011; e_fl = 4'b0010;
            end else if (redirect) begin
                e_fl = 4'b1100;
            end else if (load_stall) begin
                e_en = 5'b00111; e_fl = 4'b0100;
            end
            e_ctl = rst ? C_RST : {e_en, e_fl, e_start, e_exp};
            chk("rnd_ctl", 32'(ctl), 32'(e_ctl));
            chk("rnd_cnt", 32'(stall_cnt), 32'(m_cnt));
            chk("rnd_err", 32'(md_timeout_err), 32'(m_err));
            tick();
            if (rst) begin
                m_running = 0; m_parked = 0; m_err = 0; m_age = 0; m_cnt = 0;
            end else begin
                if (e_start) begin
                    m_running = 1; m_age = 1;
                end else if (m_running) begin
                    if (e_fin) begin
                        m_running = 0; m_parked = e_hold;
                    end else begin
                        m_age++;
                    end
                end else if (m_parked && !e_hold) begin
                    m_parked = 0;
                end
                if (e_exp) m_err = 1;
                if (perf_clr) m_cnt = 0;
                else if (!e_ctl[10]) m_cnt = (m_cnt + 1) % (1 << CW);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
